l2_cache_assoc: RTL and testbench
=================================

Name: l2_cache_assoc

Overview:
Parametrised N-way set-associative, write-back, write-allocate L2 cache between the L1 cache and main memory. It replaces the single-mode L2 with configurable sets, ways and line length, true-LRU replacement, multi-beat line fill and dirty-line writeback over a per-word memory handshake. Hit and miss counters are exposed for performance monitoring.

Parameters:
DATA_WIDTH, 32, word width in bits (multiple of 8).
ADDR_WIDTH, 32, byte address width.
NUM_SETS, 16, number of sets (power of 2, >=2).
NUM_WAYS, 2, associativity (power of 2, >=2).
WORDS_PER_LINE, 4, words per line (power of 2, >=2).

Ports:
clk  in  1  clock, all logic on rising edge.
rst  in  1  synchronous, active-high reset.
l1_cache_addr  in  ADDR_WIDTH  byte address; low log2(DATA_WIDTH/8) bits ignored.
l1_cache_data_in  in  DATA_WIDTH  write data.
l1_cache_read  in  1  read request, held until l1_cache_ready.
l1_cache_write  in  1  write request, held until l1_cache_ready; read has priority if both high.
l1_cache_data_out  out  DATA_WIDTH  read data, valid while l1_cache_ready=1.
l1_cache_ready  out  1  one-cycle completion pulse.
mem_addr  out  ADDR_WIDTH  word-aligned beat address.
mem_data_out  out  DATA_WIDTH  writeback data.
mem_data_in  in  DATA_WIDTH  fill data, sampled when mem_ready=1.
mem_read  out  1  fill beat request.
mem_write  out  1  writeback beat request.
mem_ready  in  1  beat complete.
hit_count  out  32  completed hits since reset, wraps.
miss_count  out  32  misses since reset, wraps.

Behaviour:
- Address split: offset = log2(DATA_WIDTH/8)+log2(WORDS_PER_LINE) bits, index = log2(NUM_SETS) bits above offset, tag = remainder.
- Reset: state IDLE; all outputs 0; all valid/dirty bits cleared; LRU age[w]=w in every set; counters 0. Data/tag arrays need not be reset. Reset mid-operation abandons the transfer; dirty data is lost.
- States: IDLE, LOOKUP, WB, FILL, DONE.
- IDLE: read or write high at edge -> latch addr, data, op; go LOOKUP.
- LOOKUP: compare tag in all ways of the set. Hit -> read: data_out = word; write: word updated, dirty=1; LRU update; hit_count+1; go DONE. Miss -> miss_count+1; choose victim = lowest-index invalid way, else way with age NUM_WAYS-1; victim valid and dirty -> WB, else FILL.
- Hit latency: request sampled at edge T, l1_cache_ready=1 during cycle T+2.
- WB: beats i=0..WORDS_PER_LINE-1; mem_write=1, mem_addr = victim line base + i*(DATA_WIDTH/8), mem_data_out = victim word i; held stable until mem_ready sampled 1, then next beat on following cycle with mem_write still high. After last beat -> FILL, mem_write=0.
- FILL: same beat protocol with mem_read=1 at requested line base; word i written on mem_ready. After last beat: tag written, valid=1, dirty=0, mem_read=0; then complete the original op exactly as a hit (write merges, sets dirty) and go DONE. Not counted as a hit.
- mem_read and mem_write never both 1.
- DONE: l1_cache_ready=1 for exactly one cycle; return to IDLE. Request inputs ignored in DONE; requestor deasserts in the cycle after ready.
- LRU: on access to way h, every way with age < age[h] increments, age[h]=0; ages remain a permutation of 0..NUM_WAYS-1.
- l1_cache_data_out holds last value outside ready; undefined meaning when ready=0.

Test Plan:
Defaults (offset [3:0], index [7:4]). Cold read 0x108, memory returns 0xA0,0xA1,0xA2,0xA3 -> fill beats at 0x100,0x104,0x108,0x10C, no mem_write, data_out=0xA2, miss_count=1.
Then read 0x10C -> ready at T+2, data 0xA3, no mem_read/mem_write, hit_count=1.
Write 0x104=0xDEADBEEF (hit), read 0x200 (miss, way1), read 0x300 -> writeback beats 0x100..0x10C with data 0xA0,0xDEADBEEF,0xA2,0xA3, then fill from 0x300.
After reset: load 0x100, 0x200, read 0x100 (hit), read 0x300 -> victim 0x200 clean: no mem_write; subsequent read 0x100 hits.
mem_ready held low 5 cycles per beat -> mem_addr/mem_read stable throughout, no beat advance, correct final data.
Assert rst after 2 fill beats -> next cycle all outputs 0, counters 0; read 0x100 again -> full 4-beat fill, miss_count=1.

Source files
------------

// File: rtl/l2_cache_assoc.sv
// l2_cache_assoc: N-way set-associative write-back, write-allocate L2 cache
// with true-LRU replacement and per-word memory beats for fill and writeback.
module l2_cache_assoc #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int NUM_SETS       = 16,
    parameter int NUM_WAYS       = 2,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] l1_cache_addr,
    input  logic [DATA_WIDTH-1:0] l1_cache_data_in,
    input  logic                  l1_cache_read,
    input  logic                  l1_cache_write,
    output logic [DATA_WIDTH-1:0] l1_cache_data_out,
    output logic                  l1_cache_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_out,
    input  logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_read,
    output logic                  mem_write,
    input  logic                  mem_ready,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
);
    localparam int BYTE_BITS = $clog2(DATA_WIDTH / 8);
    localparam int WORD_BITS = $clog2(WORDS_PER_LINE);
    localparam int OFF_BITS  = BYTE_BITS + WORD_BITS;
    localparam int IDX_BITS  = $clog2(NUM_SETS);
    localparam int TAG_BITS  = ADDR_WIDTH - OFF_BITS - IDX_BITS;
    localparam int WAY_BITS  = $clog2(NUM_WAYS);
    localparam int STEP      = DATA_WIDTH / 8;

    typedef enum logic [2:0] {IDLE, LOOKUP, WB, FILL, DONE} state_t;
    state_t state;

    logic [DATA_WIDTH-1:0] data_mem [NUM_SETS][NUM_WAYS][WORDS_PER_LINE];
    logic [TAG_BITS-1:0]   tag_mem  [NUM_SETS][NUM_WAYS];
    logic [WAY_BITS-1:0]   age      [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0]   valid    [NUM_SETS];
    logic [NUM_WAYS-1:0]   dirty    [NUM_SETS];

    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_data;
    logic                  req_write, refill, hit, has_invalid, unused_bits;
    logic [WAY_BITS-1:0]   victim, hit_way, pick;
    logic [WORD_BITS-1:0]  beat, word;
    logic [IDX_BITS-1:0]   idx;
    logic [TAG_BITS-1:0]   tag;

    assign idx         = req_addr[OFF_BITS +: IDX_BITS];
    assign tag         = req_addr[ADDR_WIDTH-1 -: TAG_BITS];
    assign word        = req_addr[BYTE_BITS +: WORD_BITS];
    assign unused_bits = ^req_addr[BYTE_BITS-1:0];

    // Descending scan leaves the lowest-index invalid way in pick.
    always_comb begin
        hit         = 1'b0;
        hit_way     = '0;
        pick        = '0;
        has_invalid = 1'b0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (valid[idx][w] && tag_mem[idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = WAY_BITS'(w);
            end
            if (!valid[idx][w]) begin
                has_invalid = 1'b1;
                pick        = WAY_BITS'(w);
            end
        end
        if (!has_invalid)
            for (int w = 0; w < NUM_WAYS; w++)
                if (age[idx][w] == WAY_BITS'(NUM_WAYS - 1)) pick = WAY_BITS'(w);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            req_addr          <= '0;
            req_data          <= '0;
            req_write         <= 1'b0;
            refill            <= 1'b0;
            victim            <= '0;
            beat              <= '0;
            l1_cache_data_out <= '0;
            l1_cache_ready    <= 1'b0;
            mem_addr          <= '0;
            mem_data_out      <= '0;
            mem_read          <= 1'b0;
            mem_write         <= 1'b0;
            hit_count         <= '0;
            miss_count        <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid[s] <= '0;
                dirty[s] <= '0;
                for (int w = 0; w < NUM_WAYS; w++) age[s][w] <= WAY_BITS'(w);
            end
        end else begin
            case (state)
                IDLE: if (l1_cache_read || l1_cache_write) begin
                    req_addr  <= l1_cache_addr;
                    req_data  <= l1_cache_data_in;
                    req_write <= !l1_cache_read;
                    state     <= LOOKUP;
                end
                // A refill re-enters LOOKUP and completes as a hit without counting one.
                LOOKUP: if (hit) begin
                    if (req_write) begin
                        data_mem[idx][hit_way][word] <= req_data;
                        dirty[idx][hit_way]          <= 1'b1;
                    end else
                        l1_cache_data_out <= data_mem[idx][hit_way][word];
                    for (int w = 0; w < NUM_WAYS; w++)
                        if (age[idx][w] < age[idx][hit_way]) age[idx][w] <= age[idx][w] + 1'b1;
                    age[idx][hit_way] <= '0;
                    if (!refill) hit_count <= hit_count + 32'd1;
                    refill         <= 1'b0;
                    l1_cache_ready <= 1'b1;
                    state          <= DONE;
                end else begin
                    miss_count <= miss_count + 32'd1;
                    victim     <= pick;
                    beat       <= '0;
                    if (valid[idx][pick] && dirty[idx][pick]) begin
                        mem_write    <= 1'b1;
                        mem_addr     <= {tag_mem[idx][pick], idx, {OFF_BITS{1'b0}}};
                        mem_data_out <= data_mem[idx][pick][0];
                        state        <= WB;
                    end else begin
                        mem_read <= 1'b1;
                        mem_addr <= {tag, idx, {OFF_BITS{1'b0}}};
                        state    <= FILL;
                    end
                end
                WB: if (mem_ready) begin
                    if (&beat) begin
                        mem_write <= 1'b0;
                        mem_read  <= 1'b1;
                        mem_addr  <= {tag, idx, {OFF_BITS{1'b0}}};
                        beat      <= '0;
                        state     <= FILL;
                    end else begin
                        beat         <= beat + 1'b1;
                        mem_addr     <= mem_addr + ADDR_WIDTH'(STEP);
                        mem_data_out <= data_mem[idx][victim][beat + 1'b1];
                    end
                end
                FILL: if (mem_ready) begin
                    data_mem[idx][victim][beat] <= mem_data_in;
                    if (&beat) begin
                        tag_mem[idx][victim] <= tag;
                        valid[idx][victim]   <= 1'b1;
                        dirty[idx][victim]   <= 1'b0;
                        mem_read             <= 1'b0;
                        refill               <= 1'b1;
                        state                <= LOOKUP;
                    end else begin
                        beat     <= beat + 1'b1;
                        mem_addr <= mem_addr + ADDR_WIDTH'(STEP);
                    end
                end
                DONE: begin
                    l1_cache_ready <= 1'b0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_l2_cache_assoc.sv
// tb_l2_cache_assoc: directed and random checks of l2_cache_assoc against an
// MRU-ordered line-list model with a sparse backing memory.
module tb_l2_cache_assoc;
    localparam int NS = 16;
    localparam int NW = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] l1_cache_addr = '0;
    logic [31:0] l1_cache_data_in = '0;
    logic        l1_cache_read = 1'b0;
    logic        l1_cache_write = 1'b0;
    logic [31:0] l1_cache_data_out;
    logic        l1_cache_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_out;
    logic [31:0] mem_data_in = '0;
    logic        mem_read, mem_write;
    logic        mem_ready = 1'b0;
    logic [31:0] hit_count, miss_count;

    int total = 0;
    int bad = 0;
    int fixed_lat = -1;

    always #5 clk = ~clk;

    l2_cache_assoc dut (
        .clk(clk), .rst(rst),
        .l1_cache_addr(l1_cache_addr), .l1_cache_data_in(l1_cache_data_in),
        .l1_cache_read(l1_cache_read), .l1_cache_write(l1_cache_write),
        .l1_cache_data_out(l1_cache_data_out), .l1_cache_ready(l1_cache_ready),
        .mem_addr(mem_addr), .mem_data_out(mem_data_out), .mem_data_in(mem_data_in),
        .mem_read(mem_read), .mem_write(mem_write), .mem_ready(mem_ready),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    typedef struct packed {
        logic [23:0]      tag;
        logic             dirty;
        logic [3:0][31:0] w;
    } line_t;

    logic [31:0] mem [int unsigned];
    line_t       sets [NS][$];
    logic [64:0] obs_q[$], exp_q[$];
    int          m_hits, m_misses;
    logic [31:0] q_obs, q_exp;
    int          cyc_obs;
    bit          hit_exp;

    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    function automatic bit beats_match();
        if (obs_q.size() != exp_q.size()) return 1'b0;
        foreach (obs_q[i]) if (obs_q[i] !== exp_q[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int n_writes();
        int n = 0;
        foreach (obs_q[i]) n += int'(obs_q[i][64]);
        return n;
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < NS; s++) sets[s].delete();
        m_hits = 0;
        m_misses = 0;
    endfunction

    // Each set is a list ordered most- to least-recently used.
    function automatic void model_op(input bit wr, input logic [31:0] a, input logic [31:0] d);
        logic [3:0]  s;
        logic [31:0] base, ba;
        int          k, wi;
        line_t       ln;
        s = a[7:4];
        base = {a[31:4], 4'b0};
        wi = int'(a[3:2]);
        k = -1;
        exp_q.delete();
        for (int i = 0; i < sets[s].size(); i++) if (sets[s][i].tag == a[31:8]) k = i;
        if (k >= 0) begin
            ln = sets[s][k];
            sets[s].delete(k);
            m_hits++;
            hit_exp = 1'b1;
        end else begin
            m_misses++;
            hit_exp = 1'b0;
            if (sets[s].size() == NW) begin
                ln = sets[s].pop_back();
                if (ln.dirty)
                    for (int j = 0; j < 4; j++) begin
                        ba = {ln.tag, s, 4'b0} + 32'(j * 4);
                        exp_q.push_back({1'b1, ba, ln.w[j]});
                    end
            end
            ln.tag = a[31:8];
            ln.dirty = 1'b0;
            for (int j = 0; j < 4; j++) begin
                ba = base + 32'(j * 4);
                ln.w[j] = rd_mem(ba);
                exp_q.push_back({1'b0, ba, 32'h0});
            end
        end
        if (wr) begin
            ln.w[wi] = d;
            ln.dirty = 1'b1;
        end
        q_exp = ln.w[wi];
        sets[s].push_front(ln);
    endfunction

    task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] d);
        int          waited, cur_lat;
        logic [65:0] held;
        obs_q.delete();
        l1_cache_addr = a;
        l1_cache_data_in = d;
        l1_cache_read = !wr;
        l1_cache_write = wr;
        cyc_obs = 0;
        waited = 0;
        cur_lat = 0;
        held = '0;
        while (1) begin
            @(posedge clk); #1;
            cyc_obs++;
            mem_ready = 1'b0;
            if (l1_cache_ready) break;
            if (cyc_obs > 400) begin
                total++; bad++;
                $display("FAIL timeout: no ready after %0d cycles, addr %h", cyc_obs, a);
                break;
            end
            if (mem_read && mem_write) begin
                total++; bad++;
                $display("FAIL rw_excl: mem_read=%b mem_write=%b, want not both", mem_read, mem_write);
            end
            if (mem_read || mem_write) begin
                if (waited == 0) begin
                    held = {mem_addr, mem_read, mem_write, mem_data_out};
                    cur_lat = fixed_lat >= 0 ? fixed_lat : int'($urandom_range(0, 3));
                end else begin
                    total++;
                    if ({mem_addr, mem_read, mem_write, mem_data_out} !== held) begin
                        bad++;
                        $display("FAIL stall_stable: got %h want %h", {mem_addr, mem_read, mem_write, mem_data_out}, held);
                    end
                end
                if (waited >= cur_lat) begin
                    mem_ready = 1'b1;
                    if (mem_read) mem_data_in = rd_mem(mem_addr);
                    else mem[mem_addr] = mem_data_out;
                    obs_q.push_back({mem_write, mem_addr, mem_write ? mem_data_out : 32'h0});
                    waited = 0;
                end else waited++;
            end
        end
        q_obs = l1_cache_data_out;
        l1_cache_read = 1'b0;
        l1_cache_write = 1'b0;
        @(posedge clk); #1;
        total++;
        if (l1_cache_ready !== 1'b0) begin
            bad++;
            $display("FAIL ready_pulse: ready=%b one cycle after completion, want 0", l1_cache_ready);
        end
    endtask

    task automatic op(input bit wr, input logic [31:0] a, input logic [31:0] d);
        model_op(wr, a, d);
        access(wr, a, d);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        mem_ready = 1'b0;
        l1_cache_read = 1'b0;
        l1_cache_write = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        total++;
        if ({l1_cache_data_out, l1_cache_ready, mem_addr, mem_data_out, mem_read, mem_write, hit_count, miss_count} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: ready=%b rd=%b wr=%b addr=%h hits=%0d misses=%0d, want all 0",
                     l1_cache_ready, mem_read, mem_write, mem_addr, hit_count, miss_count);
        end
    endtask

    task automatic test_cold_fill();
        for (int j = 0; j < 4; j++) mem[32'h100 + 32'(j * 4)] = 32'hA0 + 32'(j);
        op(1'b0, 32'h108, 32'h0);
        total += 4;
        if (q_obs !== 32'hA2) begin bad++; $display("FAIL cold_data: got %h want %h", q_obs, 32'hA2); end
        if (!beats_match()) begin bad++; $display("FAIL cold_beats: got %0d beats want %0d", obs_q.size(), exp_q.size()); end
        if (n_writes() !== 0) begin bad++; $display("FAIL cold_nowrite: got %0d writes want 0", n_writes()); end
        if (miss_count !== 32'd1) begin bad++; $display("FAIL cold_miss: got %0d want 1", miss_count); end
    endtask

    task automatic test_hit();
        op(1'b0, 32'h10C, 32'h0);
        total += 4;
        if (cyc_obs !== 2) begin bad++; $display("FAIL hit_latency: got %0d want 2", cyc_obs); end
        if (q_obs !== 32'hA3) begin bad++; $display("FAIL hit_data: got %h want %h", q_obs, 32'hA3); end
        if (obs_q.size() !== 0) begin bad++; $display("FAIL hit_nomem: got %0d beats want 0", obs_q.size()); end
        if (hit_count !== 32'd1) begin bad++; $display("FAIL hit_count: got %0d want 1", hit_count); end
    endtask

    task automatic test_writeback();
        logic [31:0] wb_exp [4] = '{32'hA0, 32'hDEADBEEF, 32'hA2, 32'hA3};
        op(1'b1, 32'h104, 32'hDEADBEEF);
        total++;
        if (cyc_obs !== 2) begin bad++; $display("FAIL wr_hit_latency: got %0d want 2", cyc_obs); end
        op(1'b0, 32'h200, 32'h0);
        total += 2;
        if (n_writes() !== 0) begin bad++; $display("FAIL way1_nowrite: got %0d writes want 0", n_writes()); end
        if (q_obs !== q_exp) begin bad++; $display("FAIL way1_data: got %h want %h", q_obs, q_exp); end
        op(1'b0, 32'h300, 32'h0);
        total += 2;
        if (!beats_match()) begin bad++; $display("FAIL wb_beats: got %0d beats want %0d", obs_q.size(), exp_q.size()); end
        if (obs_q.size() != 8) begin bad++; $display("FAIL wb_count: got %0d beats want 8", obs_q.size()); end
        else
            for (int j = 0; j < 4; j++) begin
                total++;
                if (obs_q[j] !== {1'b1, 32'h100 + 32'(j * 4), wb_exp[j]}) begin
                    bad++;
                    $display("FAIL wb_word%0d: got %h want %h", j, obs_q[j], {1'b1, 32'h100 + 32'(j * 4), wb_exp[j]});
                end
            end
        op(1'b0, 32'h104, 32'h0);
        total++;
        if (q_obs !== 32'hDEADBEEF) begin bad++; $display("FAIL refetch_dirty: got %h want %h", q_obs, 32'hDEADBEEF); end
    endtask

    task automatic test_clean_victim();
        test_reset();
        op(1'b0, 32'h100, 32'h0);
        op(1'b0, 32'h200, 32'h0);
        op(1'b0, 32'h100, 32'h0);
        op(1'b0, 32'h300, 32'h0);
        total += 2;
        if (n_writes() !== 0) begin bad++; $display("FAIL clean_nowrite: got %0d writes want 0", n_writes()); end
        if (!beats_match()) begin bad++; $display("FAIL clean_beats: got %0d beats want %0d", obs_q.size(), exp_q.size()); end
        op(1'b0, 32'h100, 32'h0);
        total += 3;
        if (cyc_obs !== 2) begin bad++; $display("FAIL lru_keep_latency: got %0d want 2", cyc_obs); end
        if (hit_count !== 32'd2) begin bad++; $display("FAIL lru_keep_hits: got %0d want 2", hit_count); end
        if (q_obs !== q_exp) begin bad++; $display("FAIL lru_keep_data: got %h want %h", q_obs, q_exp); end
    endtask

    task automatic test_stall();
        fixed_lat = 5;
        op(1'b0, 32'h480, 32'h0);
        op(1'b1, 32'h488, 32'h12345678);
        op(1'b0, 32'h580, 32'h0);
        op(1'b0, 32'h680, 32'h0);
        total += 2;
        if (!beats_match()) begin bad++; $display("FAIL stall_beats: got %0d beats want %0d", obs_q.size(), exp_q.size()); end
        if (q_obs !== q_exp) begin bad++; $display("FAIL stall_data: got %h want %h", q_obs, q_exp); end
        op(1'b0, 32'h488, 32'h0);
        total++;
        if (q_obs !== 32'h12345678) begin bad++; $display("FAIL stall_wb_data: got %h want %h", q_obs, 32'h12345678); end
        fixed_lat = -1;
    endtask

    task automatic test_reset_mid_fill();
        int acc = 0;
        int cyc = 0;
        test_reset();
        l1_cache_addr = 32'h100;
        l1_cache_read = 1'b1;
        while (acc < 2 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            mem_ready = 1'b0;
            if (mem_read) begin
                mem_ready = 1'b1;
                mem_data_in = rd_mem(mem_addr);
                acc++;
            end
        end
        total++;
        if (acc != 2) begin bad++; $display("FAIL midfill_beats: got %0d beats want 2", acc); end
        @(posedge clk); #1;
        mem_ready = 1'b0;
        l1_cache_read = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({l1_cache_data_out, l1_cache_ready, mem_addr, mem_data_out, mem_read, mem_write, hit_count, miss_count} !== '0) begin
            bad++;
            $display("FAIL midfill_reset: rd=%b addr=%h misses=%0d, want all 0", mem_read, mem_addr, miss_count);
        end
        rst = 1'b0;
        model_reset();
        op(1'b0, 32'h100, 32'h0);
        total += 3;
        if (!beats_match() || obs_q.size() != 4) begin bad++; $display("FAIL refill_beats: got %0d beats want 4", obs_q.size()); end
        if (miss_count !== 32'd1) begin bad++; $display("FAIL refill_miss: got %0d want 1", miss_count); end
        if (q_obs !== q_exp) begin bad++; $display("FAIL refill_data: got %h want %h", q_obs, q_exp); end
    endtask

    task automatic test_random();
        logic [31:0] a, d;
        bit          wr;
        test_reset();
        for (int n = 0; n < 80; n++) begin
            a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 4) |
                (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            d = $urandom;
            wr = $urandom_range(0, 2) == 0;
            op(wr, a, d);
            total += 3;
            if (!wr && q_obs !== q_exp) begin bad++; $display("FAIL rnd_data[%0d]: addr %h got %h want %h", n, a, q_obs, q_exp); end
            if (!beats_match()) begin bad++; $display("FAIL rnd_beats[%0d]: addr %h got %0d beats want %0d", n, a, obs_q.size(), exp_q.size()); end
            if (hit_count !== 32'(m_hits) || miss_count !== 32'(m_misses)) begin
                bad++;
                $display("FAIL rnd_counts[%0d]: got %0d/%0d want %0d/%0d", n, hit_count, miss_count, m_hits, m_misses);
            end
            if (hit_exp) begin
                total++;
                if (cyc_obs !== 2) begin bad++; $display("FAIL rnd_hit_latency[%0d]: got %0d want 2", n, cyc_obs); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_cold_fill();
        test_hit();
        test_writeback();
        test_clean_victim();
        test_stall();
        test_reset_mid_fill();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
